// File: rtl/mm_write_responder.sv
// ---------------------------------------------------------------------------
// mm_write_responder
//   Avalon-MM responder that ends the 8-bit write stream coming from the MM
//   master. Each transfer is held off by WAIT_CYCLES waitrequest-high cycles.
//   The transfer is then accepted in a single ACK cycle. Accepted writes land
//   in a DEPTH-entry register bank. A write count, the last address and data,
//   and sticky error flags are exported on conduits.
//
//   Optional feature macro: MM_RESP_READ_EN. When it is defined, a read port
//   is added and reads use the same IDLE/WAIT/ACK handshake as writes.
//
// Parameters
//   DEPTH        register bank entries, valid addresses 0..DEPTH-1 (2..256)
//   WAIT_CYCLES  extra waitrequest-high cycles per transfer (0..15)
//
// Ports
//   csi_clk             clock, rising edge
//   rsi_reset           synchronous active-high reset
//   avs_s0_address      transfer address
//   avs_s0_write        write request, held until waitrequest is low
//   avs_s0_writedata    write data
//   avs_s0_waitrequest  high = transfer not accepted this cycle
//   avs_s0_read         read request            (MM_RESP_READ_EN only)
//   avs_s0_readdata     read data in ACK cycle  (MM_RESP_READ_EN only)
//   coe_c0_reg_sel      bank observe index
//   coe_c0_reg_q        bank[reg_sel], 0 if reg_sel >= DEPTH
//   coe_c0_wr_count     accepted in-range writes, modulo 256
//   coe_c0_last_addr    address of last accepted write
//   coe_c0_last_data    data of last accepted write
//   coe_c0_err          sticky: [0] protocol abort, [1] out-of-range access
//   coe_c0_err_clr      clears coe_c0_err at the next edge
// ---------------------------------------------------------------------------
module mm_write_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       csi_clk,
  input  logic       rsi_reset,
  input  logic [7:0] avs_s0_address,
  input  logic       avs_s0_write,
  input  logic [7:0] avs_s0_writedata,
  output logic       avs_s0_waitrequest,
`ifdef MM_RESP_READ_EN
  input  logic       avs_s0_read,
  output logic [7:0] avs_s0_readdata,
`endif
  input  logic [7:0] coe_c0_reg_sel,
  output logic [7:0] coe_c0_reg_q,
  output logic [7:0] coe_c0_wr_count,
  output logic [7:0] coe_c0_last_addr,
  output logic [7:0] coe_c0_last_data,
  output logic [1:0] coe_c0_err,
  input  logic       coe_c0_err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       rd_q, rd_d;          // transfer in flight is a read
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] la_q, la_d;
  logic [7:0] ld_q, ld_d;
  logic [1:0] err_q, err_d;
  logic [1:0] err_set;
  logic       bank_we;
  logic       rd_req, req, in_range;
  logic [7:0] bank_q [DEPTH];

  wire [AW-1:0] addr_idx = avs_s0_address[AW-1:0];
  wire [AW-1:0] sel_idx  = coe_c0_reg_sel[AW-1:0];

`ifdef MM_RESP_READ_EN
  assign rd_req = avs_s0_read;
`else
  assign rd_req = 1'b0;
`endif

  // The request being tracked is whichever kind started the transfer.
  // Withdrawing that request before completion counts as an abort.
  assign req      = rd_q ? rd_req : avs_s0_write;
  assign in_range = {1'b0, avs_s0_address} < 9'(DEPTH);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rd_d    = rd_q;
    err_set = 2'b00;
    bank_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avs_s0_write || rd_req) begin
          rd_d       = !avs_s0_write;       // write wins a simultaneous request
          err_set[0] = avs_s0_write && rd_req;
          wcnt_d     = 4'(WAIT_CYCLES);
          state_d    = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d    = IDLE;
          err_set[0] = 1'b1;
        end else if (wcnt_q == 4'd1) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (!req)           err_set[0] = 1'b1;
        else if (!in_range) err_set[1] = 1'b1;
        else if (!rd_q)     bank_we    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    la_d  = la_q;
    ld_d  = ld_q;
    if (bank_we) begin
      cnt_d = cnt_q + 8'd1;
      la_d  = avs_s0_address;
      ld_d  = avs_s0_writedata;
    end
    // A clear and a new error in the same cycle: the set wins for that bit.
    err_d = (coe_c0_err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      la_q    <= '0;
      ld_q    <= '0;
      err_q   <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      if (bank_we) bank_q[addr_idx] <= avs_s0_writedata;
    end
  end

  assign avs_s0_waitrequest = (state_q != ACK);
  assign coe_c0_reg_q       = ({1'b0, coe_c0_reg_sel} < 9'(DEPTH)) ? bank_q[sel_idx] : 8'h00;
  assign coe_c0_wr_count    = cnt_q;
  assign coe_c0_last_addr   = la_q;
  assign coe_c0_last_data   = ld_q;
  assign coe_c0_err         = err_q;

`ifdef MM_RESP_READ_EN
  assign avs_s0_readdata = (state_q == ACK && rd_q && avs_s0_read && !rsi_reset)
                         ? (in_range ? bank_q[addr_idx] : 8'hFF) : 8'h00;
`endif

endmodule

// File: tb/tb_mm_write_responder.sv
module tb_mm_write_responder;
  localparam int DEPTH = 16;
  localparam int WAITC = 2;

  logic       clk, rst;
  logic [7:0] addr, wdata, reg_sel;
  logic       write, err_clr;
  logic       waitreq;
  logic [7:0] reg_q, wr_count, last_addr, last_data;
  logic [1:0] err;
`ifdef MM_RESP_READ_EN
  logic       read;
  logic [7:0] rdata;
`endif

  mm_write_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .csi_clk           (clk),
    .rsi_reset         (rst),
    .avs_s0_address    (addr),
    .avs_s0_write      (write),
    .avs_s0_writedata  (wdata),
    .avs_s0_waitrequest(waitreq),
`ifdef MM_RESP_READ_EN
    .avs_s0_read       (read),
    .avs_s0_readdata   (rdata),
`endif
    .coe_c0_reg_sel    (reg_sel),
    .coe_c0_reg_q      (reg_q),
    .coe_c0_wr_count   (wr_count),
    .coe_c0_last_addr  (last_addr),
    .coe_c0_last_data  (last_data),
    .coe_c0_err        (err),
    .coe_c0_err_clr    (err_clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] addr, bank, cnt, la, ld;
    logic [1:0] err;
  } exp_t;

  exp_t       sb[$];
  int         nchk = 0, nerr = 0;
  logic [7:0] bank_m [256];
  logic [7:0] cnt_m, la_m, ld_m;
  logic [1:0] err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) bank_m[i] = 8'h00;
    cnt_m = 0; la_m = 0; ld_m = 0; err_m = 0;
  endtask

  task automatic check_conduits(input string tag);
    check({tag, "_cnt"}, wr_count, cnt_m);
    check({tag, "_la"}, last_addr, la_m);
    check({tag, "_ld"}, last_data, ld_m);
    check({tag, "_err"}, err, err_m);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Drive one write; expectations are queued when stimulus starts and are
  // compared once the DUT has acknowledged and the result is visible.
  task automatic do_wr(input logic [7:0] a, input logic [7:0] d, input bit clr_at_ack);
    exp_t e;
    int   lat;
    bit   got;
    if (a < DEPTH) begin
      bank_m[a] = d; cnt_m = cnt_m + 8'd1; la_m = a; ld_m = d;
    end
    if (clr_at_ack) err_m = 2'b00;
    if (a >= DEPTH) err_m[1] = 1'b1;
    e.addr = a; e.bank = (a < DEPTH) ? bank_m[a] : 8'h00;
    e.cnt = cnt_m; e.la = la_m; e.ld = ld_m; e.err = err_m;
    sb.push_back(e);
    addr = a; wdata = d; write = 1;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!waitreq) got = 1;
    end
    check("ack_lat", lat, 1 + WAITC);
    err_clr = clr_at_ack;
    @(negedge clk);
    write = 0; err_clr = 0;
    check("wreq_after_ack", waitreq, 1'b1);
    e = sb.pop_front();
    check("cnt", wr_count, e.cnt);
    check("last_addr", last_addr, e.la);
    check("last_data", last_data, e.ld);
    check("err", err, e.err);
    reg_sel = e.addr;
    #1 check("bank", reg_q, e.bank);
  endtask

  // Raise a write and withdraw it during the first WAIT cycle.
  task automatic do_abort(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; write = 1;
    @(negedge clk);
    check("abort_wreq", waitreq, 1'b1);
    write = 0;
    @(negedge clk);
    err_m[0] = 1'b1;
    check("abort_wreq_idle", waitreq, 1'b1);
    check_conduits("abort");
    reg_sel = a;
    #1 check("abort_bank", reg_q, (a < DEPTH) ? bank_m[a] : 8'h00);
  endtask

`ifdef MM_RESP_READ_EN
  task automatic do_rd(input logic [7:0] a);
    int         lat;
    bit         got;
    logic [7:0] exp;
    exp = (a < DEPTH) ? bank_m[a] : 8'hFF;
    if (a >= DEPTH) err_m[1] = 1'b1;
    addr = a; read = 1; lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!waitreq) got = 1;
      else check("rdata_idle", rdata, 8'h00);
    end
    check("rd_lat", lat, 1 + WAITC);
    check("rdata", rdata, exp);
    @(negedge clk);
    read = 0;
    check("rdata_after", rdata, 8'h00);
    check_conduits("rd");
  endtask
`endif

  initial begin
    rst = 1; write = 0; addr = 0; wdata = 0; reg_sel = 3; err_clr = 0;
`ifdef MM_RESP_READ_EN
    read = 0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_wreq", waitreq, 1'b1);
    check_conduits("rst");
    check("rst_bank", reg_q, 8'h00);
    rst = 0;
    @(negedge clk);

    // Single write with wait states.
    do_wr(8'd3, 8'h5A, 1'b0);

    // Full address sweep; addresses past DEPTH are acked but flag err[1].
    do_reset();
    for (int k = 0; k < 256; k++) do_wr(8'(k), 8'(k) + 8'h10, 1'b0);
    check("sweep_cnt", wr_count, 8'd16);
    check("sweep_err", err, 2'b10);
    check("sweep_la", last_addr, 8'd15);
    for (int k = 0; k < DEPTH; k++) begin
      reg_sel = 8'(k);
      #1 check("sweep_bank", reg_q, 8'(k) + 8'h10);
    end

    // Abort during WAIT, then clear the flags.
    do_reset();
    do_abort(8'd2, 8'hEE);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0; err_m = 2'b00;
    check("clr_err", err, 2'b00);
    do_wr(8'd2, 8'h21, 1'b0);

    // Write counter wraps; a clear and a new error in the same cycle.
    do_reset();
    for (int i = 0; i < 260; i++) do_wr(8'(i % DEPTH), 8'(i) ^ 8'hA5, 1'b0);
    check("wrap_cnt", wr_count, 8'd4);
    do_abort(8'd1, 8'h00);
    do_wr(8'd200, 8'h99, 1'b1);

    // Reset in the middle of a transfer.
    addr = 8'd5; wdata = 8'h77; write = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; write = 0;
    model_reset();
    check("midrst_wreq", waitreq, 1'b1);
    check_conduits("midrst");
    reg_sel = 8'd5;
    #1 check("midrst_bank", reg_q, 8'h00);
    do_wr(8'd5, 8'h66, 1'b0);

`ifdef MM_RESP_READ_EN
    do_wr(8'd7, 8'hC3, 1'b0);
    do_rd(8'd7);
    do_rd(8'd200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
